lifo_stack: RTL and testbench

Parametrised LIFO stack: successor to the lab-7 8×8 stack. Adds generic data width and depth, a count output, a registered top-of-stack view, error pulses, and replace-top and swap-top-two operations. Sits between a producer/consumer driven by a 3-bit opcode per clock, e.g. an RPN calculator datapath. All state changes occur on the rising edge of `clk`.

---
 rtl/stack_pkg.sv | 22 ++
 rtl/stack_mem.sv | 43 ++++
 rtl/lifo_stack.sv | 179 +++++++++++++++++
 tb/tb_lifo_stack.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/stack_pkg.sv
// Shared definitions for the LIFO stack: opcode encodings and width helpers.
// No ports; imported by lifo_stack and stack_mem.
package stack_pkg;

  localparam logic [2:0] OP_NOP     = 3'b000;
  localparam logic [2:0] OP_PUSH    = 3'b001;
  localparam logic [2:0] OP_POP     = 3'b010;
  localparam logic [2:0] OP_CLEAR   = 3'b011;
  localparam logic [2:0] OP_REPLACE = 3'b100;
  localparam logic [2:0] OP_SWAP    = 3'b101;

  // Occupancy counter width: must hold every value 0..depth inclusive.
  function automatic int count_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Entry index width for an array of depth entries (depth >= 2).
  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/stack_mem.sv
// Storage array for the LIFO stack.
// Ports:
//   clk              - write clock (rising edge)
//   we_a/waddr_a/wdata_a, we_b/waddr_b/wdata_b - two independent write ports,
//                      both used in the same cycle to exchange the top two entries
//   raddr_top/rd_top, raddr_below/rd_below - two asynchronous read ports
// The array is deliberately not reset; unreachable entries simply go stale.
module stack_mem
  import stack_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int AW    = addr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             we_a,
  input  logic [AW-1:0]    waddr_a,
  input  logic [WIDTH-1:0] wdata_a,
  input  logic             we_b,
  input  logic [AW-1:0]    waddr_b,
  input  logic [WIDTH-1:0] wdata_b,
  input  logic [AW-1:0]    raddr_top,
  output logic [WIDTH-1:0] rd_top,
  input  logic [AW-1:0]    raddr_below,
  output logic [WIDTH-1:0] rd_below
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // Array write; the control logic never aims both ports at one entry.
  always_ff @(posedge clk) begin
    if (we_a) begin
      mem_r[waddr_a] <= wdata_a;
    end
    if (we_b) begin
      mem_r[waddr_b] <= wdata_b;
    end
  end

  assign rd_top   = mem_r[raddr_top];
  assign rd_below = mem_r[raddr_below];

endmodule

// File: rtl/lifo_stack.sv
// Parametrised LIFO stack driven by a 3-bit opcode every clock.
// Ports:
//   clk, rst (async, active-low)
//   operation - NOP/PUSH/POP/CLEAR/REPLACE/SWAP, sampled each rising edge
//   in        - push/replace data
//   out, out_valid - registered popped word and its one-cycle valid pulse
//   top       - registered top-of-stack view, 0 when empty
//   count, empty, full, almost_full - occupancy and status flags
//   overflow, underflow - one-cycle error pulses for illegal requests
module lifo_stack
  import stack_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int AFULL = DEPTH - 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [2:0]                  operation,
  input  logic [WIDTH-1:0]            in,
  output logic [WIDTH-1:0]            out,
  output logic                        out_valid,
  output logic [WIDTH-1:0]            top,
  output logic [count_w(DEPTH)-1:0]   count,
  output logic                        empty,
  output logic                        full,
  output logic                        almost_full,
  output logic                        overflow,
  output logic                        underflow
);

  localparam int CW = count_w(DEPTH);
  localparam int AW = addr_w(DEPTH);

  logic [CW-1:0]    count_r, count_nxt_s;
  logic [WIDTH-1:0] out_r, out_nxt_s, top_r, top_nxt_s;
  logic             out_valid_r, out_valid_nxt_s;
  logic             empty_r, full_r, afull_r;
  logic             ovf_r, ovf_nxt_s, udf_r, udf_nxt_s;

  logic             is_empty_s, is_full_s, has_two_s;
  logic [AW-1:0]    idx_push_s, idx_top_s, idx_below_s;
  logic [WIDTH-1:0] rd_top_s, rd_below_s;
  logic             we_a_s, we_b_s;
  logic [AW-1:0]    waddr_a_s, waddr_b_s;
  logic [WIDTH-1:0] wdata_a_s, wdata_b_s;

  assign is_empty_s = (count_r == CW'(0));
  assign is_full_s  = (count_r == CW'(DEPTH));
  assign has_two_s  = (count_r >= CW'(2));

  // Indices wrap harmlessly when out of range; they are only used when valid.
  assign idx_push_s  = AW'(count_r);
  assign idx_top_s   = AW'(count_r - CW'(1));
  assign idx_below_s = AW'(count_r - CW'(2));

  stack_mem #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_mem (
    .clk        (clk),
    .we_a       (we_a_s),
    .waddr_a    (waddr_a_s),
    .wdata_a    (wdata_a_s),
    .we_b       (we_b_s),
    .waddr_b    (waddr_b_s),
    .wdata_b    (wdata_b_s),
    .raddr_top  (idx_top_s),
    .rd_top     (rd_top_s),
    .raddr_below(idx_below_s),
    .rd_below   (rd_below_s)
  );

  // Opcode decode: next occupancy, array writes, output word and error pulses.
  always_comb begin
    count_nxt_s     = count_r;
    out_nxt_s       = out_r;
    out_valid_nxt_s = 1'b0;
    top_nxt_s       = top_r;
    ovf_nxt_s       = 1'b0;
    udf_nxt_s       = 1'b0;
    we_a_s          = 1'b0;
    waddr_a_s       = idx_top_s;
    wdata_a_s       = in;
    we_b_s          = 1'b0;
    waddr_b_s       = idx_below_s;
    wdata_b_s       = rd_top_s;
    case (operation)
      OP_PUSH: begin
        if (is_full_s) begin
          ovf_nxt_s = 1'b1;
        end else begin
          we_a_s      = 1'b1;
          waddr_a_s   = idx_push_s;
          count_nxt_s = count_r + CW'(1);
          top_nxt_s   = in;
        end
      end
      OP_POP: begin
        if (is_empty_s) begin
          udf_nxt_s = 1'b1;
        end else begin
          out_nxt_s       = rd_top_s;
          out_valid_nxt_s = 1'b1;
          count_nxt_s     = count_r - CW'(1);
          top_nxt_s       = has_two_s ? rd_below_s : {WIDTH{1'b0}};
        end
      end
      OP_CLEAR: begin
        count_nxt_s = CW'(0);
        top_nxt_s   = {WIDTH{1'b0}};
      end
      OP_REPLACE: begin
        // An empty stack has no top to overwrite, so this degrades to a push.
        we_a_s    = 1'b1;
        top_nxt_s = in;
        if (is_empty_s) begin
          waddr_a_s   = idx_push_s;
          count_nxt_s = CW'(1);
        end else begin
          waddr_a_s   = idx_top_s;
        end
      end
      OP_SWAP: begin
        if (has_two_s) begin
          we_a_s    = 1'b1;
          waddr_a_s = idx_top_s;
          wdata_a_s = rd_below_s;
          we_b_s    = 1'b1;
          waddr_b_s = idx_below_s;
          wdata_b_s = rd_top_s;
          top_nxt_s = rd_below_s;
        end else begin
          udf_nxt_s = 1'b1;
        end
      end
      default: begin
        count_nxt_s = count_r;
      end
    endcase
  end

  // State and output registers; flags follow the post-edge occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_r     <= CW'(0);
      out_r       <= {WIDTH{1'b0}};
      out_valid_r <= 1'b0;
      top_r       <= {WIDTH{1'b0}};
      empty_r     <= 1'b1;
      full_r      <= 1'b0;
      afull_r     <= 1'b0;
      ovf_r       <= 1'b0;
      udf_r       <= 1'b0;
    end else begin
      count_r     <= count_nxt_s;
      out_r       <= out_nxt_s;
      out_valid_r <= out_valid_nxt_s;
      top_r       <= top_nxt_s;
      empty_r     <= (count_nxt_s == CW'(0));
      full_r      <= (count_nxt_s == CW'(DEPTH));
      afull_r     <= (count_nxt_s >= CW'(AFULL));
      ovf_r       <= ovf_nxt_s;
      udf_r       <= udf_nxt_s;
    end
  end

  assign count       = count_r;
  assign out         = out_r;
  assign out_valid   = out_valid_r;
  assign top         = top_r;
  assign empty       = empty_r;
  assign full        = full_r;
  assign almost_full = afull_r;
  assign overflow    = ovf_r;
  assign underflow   = udf_r;

endmodule

// File: tb/tb_lifo_stack.sv
// Self-checking bench for lifo_stack: directed scenarios plus random opcodes,
// every cycle compared against a queue-based reference stack.
module tb_lifo_stack;
  import stack_pkg::*;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int AFULL = 7;
  localparam int CW    = count_w(DEPTH);

  logic             clk;
  logic             rst;
  logic [2:0]       operation;
  logic [WIDTH-1:0] in;
  logic [WIDTH-1:0] out;
  logic             out_valid;
  logic [WIDTH-1:0] top;
  logic [CW-1:0]    count;
  logic             empty, full, almost_full, overflow, underflow;

  lifo_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AFULL(AFULL)) dut (
    .clk(clk), .rst(rst), .operation(operation), .in(in),
    .out(out), .out_valid(out_valid), .top(top), .count(count),
    .empty(empty), .full(full), .almost_full(almost_full),
    .overflow(overflow), .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [WIDTH-1:0] m_stk[$];
  logic [WIDTH-1:0] m_out;
  logic             m_ov, m_ovf, m_udf;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_stk.delete();
    m_out = '0;
    m_ov  = 1'b0;
    m_ovf = 1'b0;
    m_udf = 1'b0;
  endtask

  task automatic model_step(input logic [2:0] op, input logic [WIDTH-1:0] d);
    logic [WIDTH-1:0] t;
    m_ov  = 1'b0;
    m_ovf = 1'b0;
    m_udf = 1'b0;
    case (op)
      3'd1: if (m_stk.size() == DEPTH) m_ovf = 1'b1; else m_stk.push_back(d);
      3'd2: if (m_stk.size() == 0) m_udf = 1'b1;
            else begin m_out = m_stk.pop_back(); m_ov = 1'b1; end
      3'd3: m_stk.delete();
      3'd4: if (m_stk.size() == 0) m_stk.push_back(d); else m_stk[m_stk.size()-1] = d;
      3'd5: if (m_stk.size() < 2) m_udf = 1'b1;
            else begin
              t = m_stk[m_stk.size()-1];
              m_stk[m_stk.size()-1] = m_stk[m_stk.size()-2];
              m_stk[m_stk.size()-2] = t;
            end
      default: ;
    endcase
  endtask

  task automatic check_all(input string ctx);
    int n;
    n = m_stk.size();
    check_eq({ctx, ".count"}, 32'(count), 32'(n));
    check_eq({ctx, ".top"}, 32'(top), (n == 0) ? 32'd0 : 32'(m_stk[n-1]));
    check_eq({ctx, ".out"}, 32'(out), 32'(m_out));
    check_eq({ctx, ".out_valid"}, 32'(out_valid), 32'(m_ov));
    check_eq({ctx, ".empty"}, 32'(empty), 32'(n == 0));
    check_eq({ctx, ".full"}, 32'(full), 32'(n == DEPTH));
    check_eq({ctx, ".almost_full"}, 32'(almost_full), 32'(n >= AFULL));
    check_eq({ctx, ".overflow"}, 32'(overflow), 32'(m_ovf));
    check_eq({ctx, ".underflow"}, 32'(underflow), 32'(m_udf));
  endtask

  // Apply one opcode on the next rising edge, then compare just after it.
  task automatic do_op(input string ctx, input logic [2:0] op, input logic [WIDTH-1:0] d);
    operation = op;
    in        = d;
    @(posedge clk);
    model_step(op, d);
    #1;
    check_all(ctx);
  endtask

  initial begin
    logic [2:0] rop;
    int r;
    rst = 1'b0;
    operation = OP_NOP;
    in = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst = 1'b1;

    // Basic push/pop ordering
    do_op("push11", OP_PUSH, 8'h11);
    do_op("push22", OP_PUSH, 8'h22);
    do_op("push33", OP_PUSH, 8'h33);
    check_eq("basic.count3", 32'(count), 32'd3);
    check_eq("basic.top33", 32'(top), 32'h33);
    for (int i = 0; i < 3; i++) do_op("pop3", OP_POP, 8'h00);
    check_eq("basic.out11", 32'(out), 32'h11);

    // Underflow cases
    do_op("pop_empty", OP_POP, 8'h00);
    check_eq("pop_empty.udf", 32'(underflow), 32'd1);
    do_op("push_one", OP_PUSH, 8'h44);
    do_op("swap_one", OP_SWAP, 8'h00);
    check_eq("swap_one.top", 32'(top), 32'h44);
    do_op("pop_one", OP_POP, 8'h00);

    // Fill to overflow
    for (int i = 1; i <= 9; i++) do_op("fill", OP_PUSH, 8'(8'h80 + i));
    check_eq("fill.count", 32'(count), 32'd8);
    check_eq("fill.top", 32'(top), 32'h88);
    do_op("fill.nop", OP_NOP, 8'h00);
    do_op("clear_full", OP_CLEAR, 8'h00);

    // Swap and replace
    do_op("pushA1", OP_PUSH, 8'hA1);
    do_op("pushB2", OP_PUSH, 8'hB2);
    do_op("swap", OP_SWAP, 8'h00);
    check_eq("swap.top", 32'(top), 32'hA1);
    do_op("popA1", OP_POP, 8'h00);
    do_op("popB2", OP_POP, 8'h00);
    do_op("repl_empty", OP_REPLACE, 8'h5C);
    check_eq("repl_empty.top", 32'(top), 32'h5C);
    do_op("repl_top", OP_REPLACE, 8'h6D);

    // Clear after several pushes
    for (int i = 1; i <= 5; i++) do_op("push5", OP_PUSH, 8'(i));
    do_op("clear", OP_CLEAR, 8'h00);
    do_op("push77", OP_PUSH, 8'h77);
    do_op("pop77", OP_POP, 8'h00);
    check_eq("pop77.out", 32'(out), 32'h77);

    // Random traffic
    for (int k = 0; k < 600; k++) begin
      r = int'($urandom_range(0, 15));
      if (r < 5)       rop = OP_PUSH;
      else if (r < 9)  rop = OP_POP;
      else if (r == 9) rop = OP_CLEAR;
      else if (r < 12) rop = OP_REPLACE;
      else if (r < 14) rop = OP_SWAP;
      else if (r == 14) rop = OP_NOP;
      else rop = 3'(6 + $urandom_range(0, 1));
      do_op("rand", rop, 8'($urandom));
    end

    // Asynchronous reset in the middle of a burst
    for (int i = 0; i < 4; i++) do_op("burst", OP_PUSH, 8'(8'hC0 + i));
    do_op("burst.pop", OP_POP, 8'h00);
    #3;
    rst = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    @(negedge clk);
    rst = 1'b1;
    do_op("post_rst", OP_PUSH, 8'h3C);
    check_eq("post_rst.count", 32'(count), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
